// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control encodings, sequencer state type and operand width
// for the EX-stage multiply sequencer.
package alu_ctrl_pkg;

    localparam logic [1:0] ALU_OP_AND = 2'b00;
    localparam logic [1:0] ALU_OP_OR  = 2'b01;
    localparam logic [1:0] ALU_OP_ADD = 2'b10;
    localparam logic [1:0] ALU_OP_SLT = 2'b11;

    localparam int MUL_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } mul_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Multi-cycle 32x32->64 shift-add multiplier that drives the shared ALU, one ADD per cycle.
// Optional radix-2 Booth signed mode is enabled by defining ALU_MUL_SEQ_SIGNED_EN.
//
// state | meaning
// IDLE  | ready for a request, ALU quiet
// CALC  | one add-and-shift iteration per cycle, 32 cycles
// DONE  | product presented until the consumer accepts it
module alu_mul_seq
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH,
    parameter int CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
`ifdef ALU_MUL_SEQ_SIGNED_EN
    input  logic             signed_i,
`endif
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [WIDTH-1:0] prod_hi_o,
    output logic [WIDTH-1:0] prod_lo_o,
    output logic [WIDTH-1:0] alu_src1_o,
    output logic [WIDTH-1:0] alu_src2_o,
    output logic             alu_inv_a_o,
    output logic             alu_inv_b_o,
    output logic [1:0]       alu_op_o,
    input  logic [WIDTH-1:0] alu_result_i,
    input  logic             alu_overflow_i
);

    mul_state_e       state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_iter;
    logic [WIDTH-1:0] step_src2;
    logic             step_inv_b;
    logic             c31;
    logic             cout;
    logic             top_bit;
`ifdef ALU_MUL_SEQ_SIGNED_EN
    logic             signed_q, signed_d;
    logic             lo_m1_q, lo_m1_d;
`endif

    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid_i)  state_d = ST_CALC;
            ST_CALC: if (last_iter)    state_d = ST_DONE;
            ST_DONE: if (resp_ready_i) state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o  = (state_q == ST_IDLE);
        resp_valid_o = (state_q == ST_DONE);
        prod_hi_o    = (state_q == ST_DONE) ? hi_q : '0;
        prod_lo_o    = (state_q == ST_DONE) ? lo_q : '0;
        alu_src1_o   = (state_q == ST_CALC) ? hi_q : '0;
        alu_src2_o   = (state_q == ST_CALC) ? step_src2 : '0;
        alu_inv_a_o  = 1'b0;
        alu_inv_b_o  = (state_q == ST_CALC) ? step_inv_b : 1'b0;
        alu_op_o     = ALU_OP_ADD;
    end

    // Booth pair 10 subtracts via ADD with inverted src2; invert_b is also the carry-in.
    always_comb begin
        step_src2  = lo_q[0] ? m_q : '0;
        step_inv_b = 1'b0;
`ifdef ALU_MUL_SEQ_SIGNED_EN
        if (signed_q) begin
            step_src2 = '0;
            case ({lo_q[0], lo_m1_q})
                2'b01:   step_src2 = m_q;
                2'b10: begin
                    step_src2  = m_q;
                    step_inv_b = 1'b1;
                end
                default: step_src2 = '0;
            endcase
        end
`endif
    end

    // Adder carry-out recovered from sum bit, operand MSBs and the overflow flag.
    assign c31  = alu_result_i[WIDTH-1] ^ alu_src1_o[WIDTH-1] ^ alu_src2_o[WIDTH-1];
    assign cout = c31 ^ alu_overflow_i;

`ifdef ALU_MUL_SEQ_SIGNED_EN
    assign top_bit = signed_q ? (alu_result_i[WIDTH-1] ^ alu_overflow_i) : cout;
`else
    assign top_bit = cout;
`endif

    always_comb begin
        m_d   = m_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        cnt_d = cnt_q;
`ifdef ALU_MUL_SEQ_SIGNED_EN
        signed_d = signed_q;
        lo_m1_d  = lo_m1_q;
`endif
        if (state_q == ST_IDLE && req_valid_i) begin
            m_d   = src_a_i;
            lo_d  = src_b_i;
            hi_d  = '0;
            cnt_d = '0;
`ifdef ALU_MUL_SEQ_SIGNED_EN
            signed_d = signed_i;
            lo_m1_d  = 1'b0;
`endif
        end else if (state_q == ST_CALC) begin
            hi_d  = {top_bit, alu_result_i[WIDTH-1:1]};
            lo_d  = {alu_result_i[0], lo_q[WIDTH-1:1]};
            cnt_d = cnt_q + CNT_W'(1);
`ifdef ALU_MUL_SEQ_SIGNED_EN
            lo_m1_d = lo_q[0];
`endif
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            cnt_q <= '0;
`ifdef ALU_MUL_SEQ_SIGNED_EN
            signed_q <= 1'b0;
            lo_m1_q  <= 1'b0;
`endif
        end else begin
            m_q   <= m_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_d;
`ifdef ALU_MUL_SEQ_SIGNED_EN
            signed_q <= signed_d;
            lo_m1_q  <= lo_m1_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: behavioural ALU, directed cases and random products
// compared with 64-bit arithmetic computed in the bench.
module tb_alu_mul_seq;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [31:0] src_a_i = '0;
    logic [31:0] src_b_i = '0;
`ifdef ALU_MUL_SEQ_SIGNED_EN
    logic        signed_i = 1'b0;
`endif
    logic        resp_valid_o;
    logic        resp_ready_i = 1'b0;
    logic [31:0] prod_hi_o, prod_lo_o;
    logic [31:0] alu_src1_o, alu_src2_o;
    logic        alu_inv_a_o, alu_inv_b_o;
    logic [1:0]  alu_op_o;
    logic [31:0] alu_result_i;
    logic        alu_overflow_i;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    alu_mul_seq dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .src_a_i        (src_a_i),
        .src_b_i        (src_b_i),
`ifdef ALU_MUL_SEQ_SIGNED_EN
        .signed_i       (signed_i),
`endif
        .resp_valid_o   (resp_valid_o),
        .resp_ready_i   (resp_ready_i),
        .prod_hi_o      (prod_hi_o),
        .prod_lo_o      (prod_lo_o),
        .alu_src1_o     (alu_src1_o),
        .alu_src2_o     (alu_src2_o),
        .alu_inv_a_o    (alu_inv_a_o),
        .alu_inv_b_o    (alu_inv_b_o),
        .alu_op_o       (alu_op_o),
        .alu_result_i   (alu_result_i),
        .alu_overflow_i (alu_overflow_i)
    );

    // Combinational 32-bit ALU as the parent would wire it; carry-in is invert_b.
    logic [31:0] alu_a, alu_b, alu_sum;
    always_comb begin
        alu_a   = alu_inv_a_o ? ~alu_src1_o : alu_src1_o;
        alu_b   = alu_inv_b_o ? ~alu_src2_o : alu_src2_o;
        alu_sum = alu_a + alu_b + {31'b0, alu_inv_b_o};
        alu_overflow_i = (alu_a[31] == alu_b[31]) && (alu_sum[31] != alu_a[31]);
        case (alu_op_o)
            2'b00:   alu_result_i = alu_a & alu_b;
            2'b01:   alu_result_i = alu_a | alu_b;
            2'b10:   alu_result_i = alu_sum;
            default: alu_result_i = {31'b0, alu_sum[31] ^ alu_overflow_i};
        endcase
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        logic signed [63:0] sa, sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        if (sgn) return 64'(sa * sb);
        return {32'b0, a} * {32'b0, b};
    endfunction

    // Called at a negedge; counts rising edges until resp_valid_o is seen.
    task automatic wait_resp(output int cyc);
        cyc = 0;
        while (cyc < 100) begin
            if (resp_valid_o) break;
            @(posedge clk_i);
            cyc++;
            @(negedge clk_i);
            if (cyc == 3) begin
                check("calc_op", {62'b0, alu_op_o}, 64'h2);
                check("calc_inv_a", {63'b0, alu_inv_a_o}, 64'h0);
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input bit sgn, input int bp);
        int          cyc;
        logic [63:0] exp;
        exp = ref_mul(a, b, sgn);
        @(negedge clk_i);
        check({tag, "_ready"}, {63'b0, req_ready_o}, 64'h1);
        req_valid_i  = 1'b1;
        src_a_i      = a;
        src_b_i      = b;
        resp_ready_i = 1'b0;
`ifdef ALU_MUL_SEQ_SIGNED_EN
        signed_i = sgn;
`endif
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        src_a_i     = $urandom;
        src_b_i     = $urandom;
        wait_resp(cyc);
        check({tag, "_lat"}, 64'(cyc), 64'd32);
        check({tag, "_prod"}, {prod_hi_o, prod_lo_o}, exp);
        for (int i = 0; i < bp; i++) begin
            req_valid_i = 1'b1;
            src_a_i     = $urandom;
            src_b_i     = $urandom;
            @(posedge clk_i);
            @(negedge clk_i);
            check({tag, "_hold_valid"}, {63'b0, resp_valid_o}, 64'h1);
            check({tag, "_hold_prod"}, {prod_hi_o, prod_lo_o}, exp);
            check({tag, "_hold_ready"}, {63'b0, req_ready_o}, 64'h0);
        end
        req_valid_i  = 1'b0;
        resp_ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        resp_ready_i = 1'b0;
        check({tag, "_after_valid"}, {63'b0, resp_valid_o}, 64'h0);
        check({tag, "_after_ready"}, {63'b0, req_ready_o}, 64'h1);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ready"}, {63'b0, req_ready_o}, 64'h1);
        check({tag, "_valid"}, {63'b0, resp_valid_o}, 64'h0);
        check({tag, "_prod"}, {prod_hi_o, prod_lo_o}, 64'h0);
        check({tag, "_alu_src"}, {alu_src1_o, alu_src2_o}, 64'h0);
        check({tag, "_alu_ctl"}, {60'b0, alu_inv_a_o, alu_inv_b_o, alu_op_o}, 64'h2);
    endtask

    initial begin
        int          cyc;
        logic [31:0] ra, rb;

        #1;
        check_quiet("reset");
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;

        run_op("basic", 32'd3, 32'd5, 1'b0, 0);
        run_op("carry", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        run_op("bp", 32'h0001_0000, 32'h0001_0000, 1'b0, 10);
        run_op("zero_mult", 32'h89AB_CDEF, 32'h0, 1'b0, 1);

        // Asynchronous reset in the middle of CALC drops the operation.
        @(negedge clk_i);
        req_valid_i = 1'b1;
        src_a_i     = 32'hDEAD_BEEF;
        src_b_i     = 32'hFFFF_FFFF;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        repeat (15) @(posedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        check_quiet("midrst");
        @(negedge clk_i);
        rst_i = 1'b0;
        run_op("post_rst", 32'd7, 32'd6, 1'b0, 0);

        // Back-to-back with req_valid_i held high throughout.
        @(negedge clk_i);
        req_valid_i  = 1'b1;
        resp_ready_i = 1'b1;
        src_a_i      = 32'd2;
        src_b_i      = 32'd0;
        @(posedge clk_i);
        @(negedge clk_i);
        src_a_i = 32'h1234_5678;
        src_b_i = 32'h0000_0010;
        wait_resp(cyc);
        check("b2b1_lat", 64'(cyc), 64'd32);
        check("b2b1_prod", {prod_hi_o, prod_lo_o}, 64'h0);
        @(posedge clk_i);
        @(negedge clk_i);
        check("b2b_idle_ready", {63'b0, req_ready_o}, 64'h1);
        check("b2b_idle_valid", {63'b0, resp_valid_o}, 64'h0);
        @(posedge clk_i);
        @(negedge clk_i);
        check("b2b2_accepted", {63'b0, req_ready_o}, 64'h0);
        req_valid_i = 1'b0;
        wait_resp(cyc);
        check("b2b2_lat", 64'(cyc), 64'd32);
        check("b2b2_prod", {prod_hi_o, prod_lo_o}, 64'h0000_0001_2345_6780);
        @(posedge clk_i);
        @(negedge clk_i);
        resp_ready_i = 1'b0;
        check("b2b2_after", {63'b0, resp_valid_o}, 64'h0);

`ifdef ALU_MUL_SEQ_SIGNED_EN
        run_op("sgn_neg", 32'hFFFF_FFFE, 32'd3, 1'b1, 0);
        check("sgn_neg_const", {prod_hi_o, prod_lo_o}, 64'h0);
        run_op("uns_same", 32'hFFFF_FFFE, 32'd3, 1'b0, 0);
`endif

        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i == 3) ra = 32'hFFFF_FFFF;
            if (i == 5) rb = 32'h8000_0000;
            if (i == 7) ra = 32'h0;
`ifdef ALU_MUL_SEQ_SIGNED_EN
            run_op("rand", ra, rb, bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
`else
            run_op("rand", ra, rb, 1'b0, int'($urandom_range(0, 3)));
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
